// File: rtl/uart_pkg.sv
// Shared register-map constants and state type for the UART MMIO bridge.
package uart_pkg;

    localparam logic [3:0] DATA_OFS   = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] CTRL_OFS   = 4'h8;

    localparam int unsigned ST_RX_EMPTY    = 0;
    localparam int unsigned ST_TX_FULL     = 1;
    localparam int unsigned ST_RX_UNDERRUN = 2;
    localparam int unsigned ST_TX_DROP     = 3;

    localparam int unsigned CTRL_RX_IE = 0;
    localparam int unsigned CTRL_TX_IE = 1;

    typedef enum logic {IDLE, RESP} bridge_state_t;

endpackage

// File: rtl/uart_mmio_bridge.sv
// 32-bit memory-mapped register front end for the uart_top RX/TX FIFOs,
// with sticky error flags, interrupt enables and a registered level irq.
module uart_mmio_bridge
    import uart_pkg::*;
#(
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned DBIT     = 8,
    parameter logic [1:0]  CTRL_RST = 2'b00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              rd_uart,
    input  logic [DBIT-1:0]   r_data,
    input  logic              rx_empty,
    output logic              wr_uart,
    output logic [DBIT-1:0]   w_data,
    input  logic              tx_full,
    output logic              irq
);

    bridge_state_t r_state;
    logic          r_ready;
    logic          r_resp_valid;
    logic [31:0]   r_rdata;
    logic          r_resp_err;
    logic          r_tx_drop;
    logic          r_rx_underrun;
    logic [1:0]    r_ctrl;
    logic          r_irq;

    logic          w_accept;
    logic          w_bad;
    logic          w_ok;
    logic [1:0]    w_idx;
    logic          w_sel_data;
    logic          w_sel_status;
    logic          w_sel_ctrl;
    logic          w_be0;
    logic          w_pop;
    logic          w_push;
    logic          w_tx_drop_nx;
    logic          w_rx_underrun_nx;
    logic [1:0]    w_ctrl_nx;
    logic [31:0]   w_rdata;
    logic          w_unused_bits;

    assign w_unused_bits = ^{req_wdata[31:DBIT], req_be[3:1]};

    always_comb begin
        w_accept     = (r_state == IDLE) & r_ready & req_valid;
        w_bad        = (req_addr[1:0] != 2'b00) || ((req_addr >> 4) != '0);
        w_ok         = w_accept & ~w_bad;
        w_idx        = req_addr[3:2];
        w_sel_data   = (w_idx == DATA_OFS[3:2]);
        w_sel_status = (w_idx == STATUS_OFS[3:2]);
        w_sel_ctrl   = (w_idx == CTRL_OFS[3:2]);
        w_be0        = req_be[0];

        w_pop  = w_ok & ~req_we & w_sel_data & ~rx_empty;
        w_push = w_ok &  req_we & w_sel_data & w_be0 & ~tx_full;

        // Clear first, then OR in the set so a simultaneous set event wins.
        w_tx_drop_nx     = r_tx_drop;
        w_rx_underrun_nx = r_rx_underrun;
        if (w_ok & req_we & w_sel_status & w_be0) begin
            if (req_wdata[ST_TX_DROP])     w_tx_drop_nx     = 1'b0;
            if (req_wdata[ST_RX_UNDERRUN]) w_rx_underrun_nx = 1'b0;
        end
        if (w_ok &  req_we & w_sel_data & w_be0 & tx_full) w_tx_drop_nx     = 1'b1;
        if (w_ok & ~req_we & w_sel_data & rx_empty)        w_rx_underrun_nx = 1'b1;

        w_ctrl_nx = r_ctrl;
        if (w_ok & req_we & w_sel_ctrl & w_be0) w_ctrl_nx = req_wdata[1:0];

        w_rdata = '0;
        if (w_ok & ~req_we) begin
            if (w_sel_data & ~rx_empty) w_rdata = 32'(r_data) | (32'd1 << DBIT);
            else if (w_sel_status)      w_rdata = {28'b0, r_tx_drop, r_rx_underrun, tx_full, rx_empty};
            else if (w_sel_ctrl)        w_rdata = {30'b0, r_ctrl};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_ready       <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_rdata       <= '0;
            r_resp_err    <= 1'b0;
            r_tx_drop     <= 1'b0;
            r_rx_underrun <= 1'b0;
            r_ctrl        <= CTRL_RST;
            r_irq         <= 1'b0;
        end else begin
            r_tx_drop     <= w_tx_drop_nx;
            r_rx_underrun <= w_rx_underrun_nx;
            r_ctrl        <= w_ctrl_nx;
            r_irq         <= (w_ctrl_nx[CTRL_RX_IE] & ~rx_empty) | (w_ctrl_nx[CTRL_TX_IE] & ~tx_full)
                           | w_tx_drop_nx | w_rx_underrun_nx;
            case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_state      <= RESP;
                        r_ready      <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_rdata      <= w_rdata;
                        r_resp_err   <= w_bad;
                    end
                end
                RESP: begin
                    r_state      <= IDLE;
                    r_ready      <= 1'b1;
                    r_resp_valid <= 1'b0;
                    r_rdata      <= '0;
                    r_resp_err   <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_err   = r_resp_err;
    assign irq        = r_irq;
    assign rd_uart    = w_pop;
    assign wr_uart    = w_push;
    assign w_data     = w_push ? req_wdata[DBIT-1:0] : '0;

endmodule

// File: tb/tb_uart_mmio_bridge.sv
// Directed bench for uart_mmio_bridge: per-cycle comparison against a
// transaction-level register model plus hand-computed literal checks.
module tb_uart_mmio_bridge;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        rd_uart;
    logic [7:0]  r_data;
    logic        rx_empty;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic        tx_full;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    uart_mmio_bridge #(.ADDR_W(4), .DBIT(8), .CTRL_RST(2'b00)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rd_uart(rd_uart), .r_data(r_data), .rx_empty(rx_empty),
        .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .irq(irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Register-level model: what software would observe.
    bit        m_ready, m_rv, m_err, m_drop, m_under, m_irq;
    bit [31:0] m_rdata;
    bit [1:0]  m_ctrl;

    task automatic model_access();
        int off;
        off = int'(req_addr);
        if (off % 4 != 0) begin
            m_err = 1;
            return;
        end
        case (off / 4)
            0: if (req_we) begin
                   if (req_be[0] && tx_full) m_drop = 1;
               end else if (rx_empty) m_under = 1;
               else m_rdata = 32'h100 + 32'(r_data);
            1: if (req_we) begin
                   if (req_be[0]) begin
                       if (req_wdata[3]) m_drop  = 0;
                       if (req_wdata[2]) m_under = 0;
                   end
               end else m_rdata = 8 * 32'(m_drop) + 4 * 32'(m_under) + 2 * 32'(tx_full) + 32'(rx_empty);
            2: if (req_we) begin
                   if (req_be[0]) m_ctrl = req_wdata[1:0];
               end else m_rdata = 32'(m_ctrl);
            default: ;
        endcase
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_ready = 0; m_rv = 0; m_rdata = 0; m_err = 0;
            m_drop = 0; m_under = 0; m_ctrl = 2'b00; m_irq = 0;
        end else begin
            bit acc;
            acc = m_ready && req_valid;
            m_rv = 0; m_rdata = 0; m_err = 0;
            if (acc) begin
                model_access();
                m_rv = 1;
            end
            m_ready = !acc;
            m_irq = (m_ctrl[0] && !rx_empty) || (m_ctrl[1] && !tx_full) || m_drop || m_under;
        end
    end

    logic prev_rd = 1'b0, prev_wr = 1'b0;

    always @(negedge clk) begin
        bit live, exp_rd, exp_wr;
        live   = reset && m_ready && req_valid && (req_addr == 4'h0);
        exp_rd = live && !req_we && !rx_empty;
        exp_wr = live && req_we && req_be[0] && !tx_full;
        chk("req_ready", 32'(req_ready), 32'(m_ready));
        chk("resp_valid", 32'(resp_valid), 32'(m_rv));
        if (m_rv) begin
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_err", 32'(resp_err), 32'(m_err));
        end
        chk("irq", 32'(irq), 32'(m_irq));
        chk("rd_uart", 32'(rd_uart), 32'(exp_rd));
        chk("wr_uart", 32'(wr_uart), 32'(exp_wr));
        if (exp_wr) chk("w_data", 32'(w_data), 32'(req_wdata[7:0]));
        if (!reset) begin
            chk("rst_w_data", 32'(w_data), 0);
            chk("rst_rdata", resp_rdata, 0);
            chk("rst_err", 32'(resp_err), 0);
        end
        chk("pulse_excl", 32'(rd_uart & wr_uart), 0);
        chk("pulse_b2b", 32'((rd_uart & prev_rd) | (wr_uart & prev_wr)), 0);
        prev_rd <= rd_uart;
        prev_wr <= wr_uart;
    end

    logic [31:0] t_rdata;
    logic        t_err, t_rd, t_wr;
    logic [7:0]  t_wbyte;

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_req(input logic we, input logic [3:0] addr, input logic [31:0] wd,
                          input logic [3:0] be);
        int n;
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 8) begin
            @(posedge clk); #1;
            @(negedge clk);
            n++;
        end
        if (!req_ready) chk("ready_timeout", 32'(n), 0);
        t_rd = rd_uart; t_wr = wr_uart; t_wbyte = w_data;
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 4) begin
            @(negedge clk);
            n++;
        end
        chk("resp_latency", 32'(n), 0);
        t_rdata = resp_rdata; t_err = resp_err;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 0; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_be = 0;
        r_data = 0; rx_empty = 1; tx_full = 0;
        repeat (2) @(negedge clk);
        chk("lit_rst_ready", 32'(req_ready), 0);
        chk("lit_rst_irq", 32'(irq), 0);
        @(posedge clk); #1 reset = 1;
        @(posedge clk); #1;

        do_req(1, 4'h0, 32'h0000_0041, 4'h1);
        chk("t1_wr", 32'(t_wr), 1);
        chk("t1_wbyte", 32'(t_wbyte), 32'h41);
        chk("t1_rd", 32'(t_rd), 0);
        chk("t1_err", 32'(t_err), 0);

        rx_empty = 0; r_data = 8'h5A;
        do_req(0, 4'h0, 0, 4'hF);
        chk("t2_rd", 32'(t_rd), 1);
        chk("t2_rdata", t_rdata, 32'h0000_015A);
        rx_empty = 1;

        do_req(0, 4'h0, 0, 4'hF);
        chk("t3_rdata", t_rdata, 32'h0);
        chk("t3_rd", 32'(t_rd), 0);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t3_status", t_rdata, 32'h0000_0005);
        chk("t3_irq", 32'(irq), 1);
        do_req(1, 4'h4, 32'h4, 4'h1);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t3_cleared", t_rdata, 32'h0000_0001);

        tx_full = 1;
        do_req(1, 4'h0, 32'h33, 4'h1);
        chk("t4_wr", 32'(t_wr), 0);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t4_status", t_rdata, 32'h0000_000B);
        chk("t4_irq", 32'(irq), 1);
        do_req(1, 4'h4, 32'h8, 4'h1);
        chk("t4_irq_clr", 32'(irq), 0);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t4_status_clr", t_rdata, 32'h0000_0003);
        do_req(1, 4'h0, 32'h34, 4'h1);
        do_req(1, 4'h4, 32'h8, 4'h0);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t4_no_be_clr", t_rdata, 32'h0000_000B);
        do_req(1, 4'h4, 32'h4, 4'h1);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t4_other_clr", t_rdata, 32'h0000_000B);
        tx_full = 0;
        do_req(1, 4'h0, 32'h55, 4'h2);
        chk("t4_be0_wr", 32'(t_wr), 0);
        chk("t4_be0_err", 32'(t_err), 0);
        do_req(1, 4'h4, 32'hC, 4'h1);

        do_req(1, 4'h8, 32'h1, 4'h1);
        do_req(0, 4'h8, 0, 4'hF);
        chk("t5_ctrl", t_rdata, 32'h1);
        rx_empty = 0; r_data = 8'hC3;
        @(negedge clk);
        chk("t5_irq_lag", 32'(irq), 0);
        @(negedge clk);
        chk("t5_irq_rise", 32'(irq), 1);
        @(posedge clk); #1 rx_empty = 1;
        do_req(0, 4'h6, 0, 4'hF);
        chk("t5_mis_err", 32'(t_err), 1);
        chk("t5_mis_pulse", 32'(t_rd | t_wr), 0);
        chk("t5_mis_rdata", t_rdata, 0);
        do_req(0, 4'hC, 0, 4'hF);
        chk("t5_rsv_err", 32'(t_err), 0);
        do_req(1, 4'hC, 32'hFFFF_FFFF, 4'hF);
        chk("t5_rsv_werr", 32'(t_err), 0);
        do_req(1, 4'h8, 32'hFFFF_FFFE, 4'hF);
        do_req(0, 4'h8, 0, 4'hF);
        chk("t5_ctrl_mask", t_rdata, 32'h2);

        // Back-to-back requests: model checks the 2-cycle cadence.
        rx_empty = 0; r_data = 8'h11;
        req_valid = 1; req_we = 0; req_addr = 4'h0; req_be = 4'hF;
        repeat (8) begin
            @(posedge clk); #1 r_data = r_data + 8'h1;
        end
        req_we = 1; req_wdata = 32'h7E; req_be = 4'h1;
        repeat (6) @(posedge clk);
        #1 req_valid = 0; rx_empty = 1;
        @(posedge clk); #1;

        do_req(0, 4'h0, 0, 4'hF);
        req_valid = 1; req_we = 0; req_addr = 4'h4;
        @(posedge clk); #1;
        req_valid = 0;
        chk("t6_pre_rv", 32'(resp_valid), 1);
        reset = 0;
        #1;
        chk("t6_rv", 32'(resp_valid), 0);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_irq", 32'(irq), 0);
        chk("t6_rdata", resp_rdata, 0);
        chk("t6_pulses", 32'(rd_uart | wr_uart), 0);
        @(posedge clk); #1 reset = 1;
        begin
            int seen;
            seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (resp_valid) seen++;
            end
            chk("t6_stray_rv", 32'(seen), 0);
            chk("t6_ready_back", 32'(req_ready), 1);
        end
        @(posedge clk); #1;
        do_req(0, 4'h8, 0, 4'hF);
        chk("t6_ctrl_rst", t_rdata, 0);
        do_req(0, 4'h4, 0, 4'hF);
        chk("t6_status_rst", t_rdata, 32'h1);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
